// File: rtl/nebula_pkg.sv
// Shared AXI-Lite types for the nebula control plane.
// Response codes, write-join states and channel bundles.
package nebula_pkg;

    localparam int AXIL_ADDR_W = 12;
    localparam int AXIL_DATA_W = 32;

    typedef logic [1:0] axil_resp_t;

    localparam axil_resp_t AXIL_RESP_OKAY   = 2'b00;
    localparam axil_resp_t AXIL_RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        W_IDLE,
        W_HAVE_AW,
        W_HAVE_W,
        W_RESP
    } wr_join_e;

    typedef struct packed {
        logic                   valid;
        logic                   ready;
        logic [AXIL_ADDR_W-1:0] addr;
    } axil_ax_t;

    typedef struct packed {
        logic                     valid;
        logic                     ready;
        logic [AXIL_DATA_W-1:0]   data;
        logic [AXIL_DATA_W/8-1:0] strb;
    } axil_w_t;

    typedef struct packed {
        logic       valid;
        logic       ready;
        axil_resp_t resp;
    } axil_b_t;

    typedef struct packed {
        logic                   valid;
        logic                   ready;
        logic [AXIL_DATA_W-1:0] data;
        axil_resp_t             resp;
    } axil_r_t;

    function automatic logic [31:0] strb_mask(input logic [3:0] s);
        logic [31:0] m;
        for (int b = 0; b < 4; b++) begin
            m[8*b +: 8] = {8{s[b]}};
        end
        return m;
    endfunction

endpackage

// File: rtl/nebula_axil_wr_join.sv
// AW/W capture and join: holds whichever half arrives first and
// raises commit in the cycle the second half is accepted.
module nebula_axil_wr_join
    import nebula_pkg::*;
#(
    parameter int IDX_W  = 10,
    parameter int DATA_W = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                awvalid,
    output logic                awready,
    input  logic [IDX_W-1:0]    awidx,
    input  logic                wvalid,
    output logic                wready,
    input  logic [DATA_W-1:0]   wdata,
    input  logic [DATA_W/8-1:0] wstrb,
    output logic                bvalid,
    input  logic                bready,
    output logic                commit,
    output logic [IDX_W-1:0]    cm_idx,
    output logic [DATA_W-1:0]   cm_data,
    output logic [DATA_W/8-1:0] cm_strb
);

    wr_join_e                st;
    logic [IDX_W-1:0]        idx_q;
    logic [DATA_W-1:0]       data_q;
    logic [DATA_W/8-1:0]     strb_q;
    logic                    aw_hs;
    logic                    w_hs;
    logic                    have_aw;
    logic                    have_w;

    assign aw_hs   = awvalid & awready;
    assign w_hs    = wvalid & wready;
    assign have_aw = aw_hs | (st == W_HAVE_AW);
    assign have_w  = w_hs | (st == W_HAVE_W);
    assign commit  = have_aw & have_w;
    assign cm_idx  = (st == W_HAVE_AW) ? idx_q : awidx;
    assign cm_data = (st == W_HAVE_W) ? data_q : wdata;
    assign cm_strb = (st == W_HAVE_W) ? strb_q : wstrb;

    always_ff @(posedge clk) begin
        if (rst) begin
            st      <= W_IDLE;
            awready <= 1'b0;
            wready  <= 1'b0;
            bvalid  <= 1'b0;
            idx_q   <= '0;
            data_q  <= '0;
            strb_q  <= '0;
        end else begin
            unique case (st)
                W_IDLE: begin
                    if (commit) begin
                        st      <= W_RESP;
                        awready <= 1'b0;
                        wready  <= 1'b0;
                        bvalid  <= 1'b1;
                    end else if (aw_hs) begin
                        st      <= W_HAVE_AW;
                        awready <= 1'b0;
                        idx_q   <= awidx;
                    end else if (w_hs) begin
                        st      <= W_HAVE_W;
                        wready  <= 1'b0;
                        data_q  <= wdata;
                        strb_q  <= wstrb;
                    end else begin
                        // also the first cycle out of reset
                        awready <= 1'b1;
                        wready  <= 1'b1;
                    end
                end
                W_HAVE_AW: begin
                    if (commit) begin
                        st     <= W_RESP;
                        wready <= 1'b0;
                        bvalid <= 1'b1;
                    end
                end
                W_HAVE_W: begin
                    if (commit) begin
                        st      <= W_RESP;
                        awready <= 1'b0;
                        bvalid  <= 1'b1;
                    end
                end
                W_RESP: begin
                    if (bready) begin
                        st      <= W_IDLE;
                        bvalid  <= 1'b0;
                        awready <= 1'b1;
                        wready  <= 1'b1;
                    end
                end
                default: st <= W_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/nebula_axil_regfile.sv
// AXI4-Lite register file with RO hardware slots and write pulses.
// Define NEBULA_AXIL_REGFILE_IRQ_EN for the IER/STATUS interrupt pair.
module nebula_axil_regfile
    import nebula_pkg::*;
#(
    parameter int                           NUM_REGS  = 8,
    parameter int                           ADDR_W    = 12,
    parameter int                           DATA_W    = 32,
    parameter logic [NUM_REGS*DATA_W-1:0]   RESET_VAL = '0,
    parameter logic [NUM_REGS-1:0]          RO_MASK   = '0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       awvalid,
    output logic                       awready,
    input  logic [ADDR_W-1:0]          awaddr,
    input  logic                       wvalid,
    output logic                       wready,
    input  logic [DATA_W-1:0]          wdata,
    input  logic [DATA_W/8-1:0]        wstrb,
    output logic                       bvalid,
    input  logic                       bready,
    output logic [1:0]                 bresp,
    input  logic                       arvalid,
    output logic                       arready,
    input  logic [ADDR_W-1:0]          araddr,
    output logic                       rvalid,
    input  logic                       rready,
    output logic [DATA_W-1:0]          rdata,
    output logic [1:0]                 rresp,
    output logic [NUM_REGS*DATA_W-1:0] cfg_o,
    output logic [NUM_REGS-1:0]        cfg_wr_pulse,
    input  logic [NUM_REGS*DATA_W-1:0] hw_ro_i,
    input  logic [DATA_W-1:0]          sts_set_i,
    output logic                       irq_o
);

    localparam int IDX_W = ADDR_W - 2;

`ifdef NEBULA_AXIL_REGFILE_IRQ_EN
    localparam int IER = NUM_REGS - 2;
    localparam int STS = NUM_REGS - 1;
    localparam logic [NUM_REGS-1:0] IRQ_SLOTS =
        NUM_REGS'(3) << (NUM_REGS - 2);
    localparam logic [NUM_REGS-1:0] RO_EFF = RO_MASK & ~IRQ_SLOTS;
`else
    localparam logic [NUM_REGS-1:0] RO_EFF = RO_MASK;
`endif

    logic [NUM_REGS-1:0][DATA_W-1:0] regs;
    logic [NUM_REGS-1:0][DATA_W-1:0] regs_n;
    logic [NUM_REGS-1:0][DATA_W-1:0] hw;
    logic [NUM_REGS-1:0][DATA_W-1:0] cfg;

    logic                   commit;
    logic [IDX_W-1:0]       cm_idx;
    logic [DATA_W-1:0]      cm_data;
    logic [DATA_W/8-1:0]    cm_strb;
    logic [DATA_W-1:0]      bmask;
    logic [NUM_REGS-1:0]    whit;
    logic [NUM_REGS-1:0]    wr_en;
    logic                   wr_ok;
    logic                   wr_ro;
    logic                   ar_hs;
    logic                   rv_n;
    logic                   rd_ok;
    logic [DATA_W-1:0]      rd_val;
    logic                   unused_bits;

    nebula_axil_wr_join #(
        .IDX_W  (IDX_W),
        .DATA_W (DATA_W)
    ) u_wr_join (
        .clk     (clk),
        .rst     (rst),
        .awvalid (awvalid),
        .awready (awready),
        .awidx   (awaddr[ADDR_W-1:2]),
        .wvalid  (wvalid),
        .wready  (wready),
        .wdata   (wdata),
        .wstrb   (wstrb),
        .bvalid  (bvalid),
        .bready  (bready),
        .commit  (commit),
        .cm_idx  (cm_idx),
        .cm_data (cm_data),
        .cm_strb (cm_strb)
    );

    assign hw    = hw_ro_i;
    assign cfg_o = cfg;
    assign bmask = strb_mask(cm_strb);

    always_comb begin
        for (int i = 0; i < NUM_REGS; i++) begin
            cfg[i] = RO_EFF[i] ? hw[i] : regs[i];
        end
    end

    always_comb begin
        whit = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            whit[i] = (cm_idx == IDX_W'(i));
        end
    end

    assign wr_ok = |whit;
    assign wr_ro = |(whit & RO_EFF);
    assign wr_en = {NUM_REGS{commit & ~wr_ro}} & whit;

    always_comb begin
        regs_n = regs;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (wr_en[i]) begin
                regs_n[i] = (regs[i] & ~bmask) | (cm_data & bmask);
            end
        end
`ifdef NEBULA_AXIL_REGFILE_IRQ_EN
        // W1C under strobes; a same-cycle set wins
        regs_n[STS] = (regs[STS] & ~(wr_en[STS] ? (cm_data & bmask) : '0))
                    | sts_set_i;
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            regs         <= RESET_VAL;
            cfg_wr_pulse <= '0;
            bresp        <= AXIL_RESP_OKAY;
        end else begin
            regs         <= regs_n;
            cfg_wr_pulse <= wr_en;
            if (commit) begin
                bresp <= (!wr_ok || wr_ro) ? AXIL_RESP_SLVERR : AXIL_RESP_OKAY;
            end
        end
    end

    always_comb begin
        rd_val = '0;
        rd_ok  = 1'b0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (araddr[ADDR_W-1:2] == IDX_W'(i)) begin
                rd_val = cfg[i];
                rd_ok  = 1'b1;
            end
        end
    end

    assign ar_hs = arvalid & arready;
    assign rv_n  = (rvalid & ~rready) | ar_hs;

    always_ff @(posedge clk) begin
        if (rst) begin
            arready <= 1'b0;
            rvalid  <= 1'b0;
            rdata   <= '0;
            rresp   <= AXIL_RESP_OKAY;
        end else begin
            arready <= ~rv_n;
            rvalid  <= rv_n;
            if (ar_hs) begin
                rdata <= rd_ok ? rd_val : '0;
                rresp <= rd_ok ? AXIL_RESP_OKAY : AXIL_RESP_SLVERR;
            end
        end
    end

`ifdef NEBULA_AXIL_REGFILE_IRQ_EN
    logic irq_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            irq_q <= 1'b0;
        end else begin
            irq_q <= |(regs[STS] & regs[IER]);
        end
    end

    assign irq_o       = irq_q;
    assign unused_bits = ^{awaddr[1:0], araddr[1:0]};
`else
    assign irq_o       = 1'b0;
    assign unused_bits = ^{awaddr[1:0], araddr[1:0], sts_set_i};
`endif

endmodule

// File: tb/tb_nebula_axil_regfile.sv
// Randomized bench for nebula_axil_regfile against a byte-lane model.
// Covers IER/STATUS behaviour when NEBULA_AXIL_REGFILE_IRQ_EN is set.
module tb_nebula_axil_regfile;

    localparam int NR = 8;
    localparam logic [NR-1:0] RO = 8'h20;
    localparam logic [NR*32-1:0] RV = {
        32'h0, 32'h0, 32'h1000_0005, 32'h1000_0004,
        32'h1000_0003, 32'h1000_0002, 32'h1000_0001, 32'h1000_0000
    };
`ifdef NEBULA_AXIL_REGFILE_IRQ_EN
    localparam bit IRQ = 1'b1;
`else
    localparam bit IRQ = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            awvalid = 1'b0, wvalid = 1'b0, bready = 1'b0;
    logic            arvalid = 1'b0, rready = 1'b0;
    logic            awready, wready, bvalid, arready, rvalid, irq_o;
    logic [11:0]     awaddr = '0, araddr = '0;
    logic [31:0]     wdata = '0, rdata, sts_set_i = '0;
    logic [3:0]      wstrb = '0;
    logic [1:0]      bresp, rresp;
    logic [NR*32-1:0] cfg_o, hw_ro_i;
    logic [NR-1:0]   cfg_wr_pulse;

    logic [31:0] model [NR];
    int n_checks = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    nebula_axil_regfile #(
        .NUM_REGS  (NR),
        .ADDR_W    (12),
        .DATA_W    (32),
        .RESET_VAL (RV),
        .RO_MASK   (RO)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .awvalid      (awvalid),
        .awready      (awready),
        .awaddr       (awaddr),
        .wvalid       (wvalid),
        .wready       (wready),
        .wdata        (wdata),
        .wstrb        (wstrb),
        .bvalid       (bvalid),
        .bready       (bready),
        .bresp        (bresp),
        .arvalid      (arvalid),
        .arready      (arready),
        .araddr       (araddr),
        .rvalid       (rvalid),
        .rready       (rready),
        .rdata        (rdata),
        .rresp        (rresp),
        .cfg_o        (cfg_o),
        .cfg_wr_pulse (cfg_wr_pulse),
        .hw_ro_i      (hw_ro_i),
        .sts_set_i    (sts_set_i),
        .irq_o        (irq_o)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic bit is_ro(input int idx);
        if (IRQ && idx >= NR - 2) return 1'b0;
        return RO[idx];
    endfunction

    function automatic logic [31:0] exp_val(input int idx);
        if (idx >= NR) return 32'h0;
        if (is_ro(idx)) return hw_ro_i[idx*32 +: 32];
        return model[idx];
    endfunction

    task automatic axi_write(input logic [11:0] a, input logic [31:0] d,
                             input logic [3:0] s, input int awd,
                             input int wd, input int hold);
        int idx = int'(a[11:2]);
        bit ok = idx < NR;
        bit ro = ok && is_ro(idx);
        bit aw_done = 1'b0, w_done = 1'b0, aw_acc, w_acc;
        logic [1:0] eresp = (ok && !ro) ? 2'b00 : 2'b10;
        logic [NR-1:0] epulse = '0;
        logic [31:0] clr;
        int n = 0;
        while (!(aw_done && w_done) && n < 20) begin
            awvalid = !aw_done && n >= awd;
            awaddr  = a;
            wvalid  = !w_done && n >= wd;
            wdata   = d;
            wstrb   = s;
            aw_acc  = awvalid && awready;
            w_acc   = wvalid && wready;
            check("bvalid_early", 32'(bvalid), 32'h0);
            @(posedge clk); #1;
            if (aw_acc) aw_done = 1'b1;
            if (w_acc) w_done = 1'b1;
            n++;
        end
        awvalid = 1'b0;
        wvalid  = 1'b0;
        if (!(aw_done && w_done)) begin
            check("wr_timeout", 32'h0, 32'h1);
            return;
        end
        if (ok && !ro) begin
            epulse[idx] = 1'b1;
            clr = 32'h0;
            for (int b = 0; b < 4; b++) begin
                if (s[b]) clr[8*b +: 8] = 8'hFF;
            end
            if (IRQ && idx == NR - 1)
                model[idx] = (model[idx] & ~(d & clr)) | sts_set_i;
            else
                model[idx] = (model[idx] & ~clr) | (d & clr);
        end
        check("bvalid_lat", 32'(bvalid), 32'h1);
        check("bresp", 32'(bresp), 32'(eresp));
        check("wr_pulse", 32'(cfg_wr_pulse), 32'(epulse));
        if (ok) check("cfg_o", cfg_o[idx*32 +: 32], exp_val(idx));
        for (int k = 0; k < hold; k++) begin
            @(posedge clk); #1;
            check("bvalid_hold", 32'(bvalid), 32'h1);
            check("bresp_hold", 32'(bresp), 32'(eresp));
            check("awready_hold", 32'(awready), 32'h0);
            check("wready_hold", 32'(wready), 32'h0);
            if (k == 0) check("pulse_once", 32'(cfg_wr_pulse), 32'h0);
        end
        bready = 1'b1;
        @(posedge clk); #1;
        bready = 1'b0;
        check("bvalid_drop", 32'(bvalid), 32'h0);
        check("aw_resume", 32'(awready & wready), 32'h1);
        if (hold == 0) check("pulse_once", 32'(cfg_wr_pulse), 32'h0);
    endtask

    task automatic axi_read(input logic [11:0] a, input int hold);
        int idx = int'(a[11:2]);
        logic [31:0] edata = exp_val(idx);
        logic [1:0] eresp = (idx < NR) ? 2'b00 : 2'b10;
        bit acc = 1'b0;
        int n = 0;
        arvalid = 1'b1;
        araddr  = a;
        while (!acc && n < 20) begin
            acc = arready;
            @(posedge clk); #1;
            n++;
        end
        arvalid = 1'b0;
        if (!acc) begin
            check("rd_timeout", 32'h0, 32'h1);
            return;
        end
        check("rvalid_lat", 32'(rvalid), 32'h1);
        check("rdata", rdata, edata);
        check("rresp", 32'(rresp), 32'(eresp));
        for (int k = 0; k < hold; k++) begin
            @(posedge clk); #1;
            check("rvalid_hold", 32'(rvalid), 32'h1);
            check("rdata_hold", rdata, edata);
            check("arready_hold", 32'(arready), 32'h0);
        end
        rready = 1'b1;
        @(posedge clk); #1;
        rready = 1'b0;
        check("rvalid_drop", 32'(rvalid), 32'h0);
        check("ar_resume", 32'(arready), 32'h1);
    endtask

    initial begin
        for (int i = 0; i < NR; i++) begin
            hw_ro_i[i*32 +: 32] = $urandom;
            model[i] = RV[i*32 +: 32];
        end
        repeat (3) @(posedge clk);
        #1;
        check("rst_awready", 32'(awready), 32'h0);
        check("rst_wready", 32'(wready), 32'h0);
        check("rst_arready", 32'(arready), 32'h0);
        check("rst_valids", 32'({bvalid, rvalid}), 32'h0);
        check("rst_resps", 32'({bresp, rresp}), 32'h0);
        check("rst_rdata", rdata, 32'h0);
        check("rst_pulse", 32'(cfg_wr_pulse), 32'h0);
        check("rst_irq", 32'(irq_o), 32'h0);
        check("rst_cfg0", cfg_o[31:0], 32'h1000_0000);
        check("rst_cfg5_ro", cfg_o[191:160], hw_ro_i[191:160]);
        rst = 1'b0;
        @(posedge clk); #1;
        check("post_rst_ready", 32'({awready, wready, arready}), 32'h7);

        axi_write(12'h000, 32'd12, 4'hF, 0, 0, 0);
        axi_read(12'h000, 0);
        check("idx0_val", cfg_o[31:0], 32'd12);
        axi_write(12'h004, 32'h0000_ABCD, 4'hF, 2, 0, 0);
        axi_read(12'h004, 0);
        check("idx1_abcd", cfg_o[63:32], 32'h0000_ABCD);
        axi_write(12'h006, 32'hFFFF_FFFF, 4'h2, 0, 0, 0);
        check("idx1_strb", cfg_o[63:32], 32'h0000_FFCD);
        axi_read(12'h100, 0);
        axi_write(12'h014, 32'hDEAD_BEEF, 4'hF, 0, 1, 0);
        check("ro_unchanged", cfg_o[191:160], hw_ro_i[191:160]);
        axi_write(12'h200, 32'h1234_5678, 4'hF, 1, 0, 0);
        axi_write(12'h008, 32'h5555_AAAA, 4'h0, 0, 0, 0);
        axi_write(12'h00C, 32'hCAFE_F00D, 4'hF, 0, 0, 5);
        axi_read(12'h00C, 5);

        for (int t = 0; t < 60; t++) begin
            int idx = $urandom_range(0, 9);
            logic [11:0] a;
            if (IRQ && (idx == NR - 2 || idx == NR - 1)) idx = 3;
            a = {idx[9:0], 2'($urandom_range(0, 3))};
            if ($urandom_range(0, 1) == 1)
                axi_write(a, $urandom, 4'($urandom_range(0, 15)),
                          $urandom_range(0, 2), $urandom_range(0, 2),
                          $urandom_range(0, 1));
            else
                axi_read(a, $urandom_range(0, 1));
        end

`ifdef NEBULA_AXIL_REGFILE_IRQ_EN
        axi_write(12'h018, 32'h1, 4'hF, 0, 0, 0);
        sts_set_i = 32'h1;
        @(posedge clk); #1;
        sts_set_i = 32'h0;
        model[NR-1] = model[NR-1] | 32'h1;
        @(posedge clk); #1;
        check("irq_set", 32'(irq_o), 32'h1);
        sts_set_i = 32'h1;
        axi_write(12'h01C, 32'h1, 4'hF, 0, 0, 0);
        sts_set_i = 32'h0;
        axi_read(12'h01C, 0);
        check("sts_set_wins", cfg_o[255:224] & 32'h1, 32'h1);
        axi_write(12'h01C, 32'h1, 4'hF, 0, 0, 0);
        axi_read(12'h01C, 0);
        repeat (2) @(posedge clk);
        #1;
        check("irq_clear", 32'(irq_o), 32'h0);
`else
        check("irq_tied", 32'(irq_o), 32'h0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
